// File: rtl/im2col_window_gen.sv
// Streaming 3x3 im2col window generator: raster pixels in, one 9-pixel window per
// interior position out, built from two line buffers and a 3x3 shift register.
module im2col_window_gen #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_valid,
   input  logic [DW-1:0] pix_data,
   output logic          pix_ready,
   output logic          win_valid,
   output logic [DW-1:0] win_data [0:8],
   output logic [9:0]    win_idx,
   input  logic          win_ready,
   output logic          frame_done
);

   // state  | meaning
   // S_FILL | rows 0-1 of a frame arriving, no windows possible
   // S_RUN  | windows emitted; held here until the final window is accepted
   // S_DONE | single-cycle frame_done pulse, input stalled
   typedef enum logic [1:0] {S_FILL, S_RUN, S_DONE} state_t;

   localparam int CW   = $clog2(IMG_W);
   localparam int RW   = $clog2(IMG_H);
   localparam int NWIN = (IMG_W - 2) * (IMG_H - 2);
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
   localparam logic [9:0]    LAST_IDX = 10'(NWIN - 1);

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [DW-1:0] r_lb0 [0:IMG_W-1];
   logic [DW-1:0] r_lb1 [0:IMG_W-1];
   logic [DW-1:0] r_win [0:8];
   logic [DW-1:0] w_win_sh [0:8];
   logic [DW-1:0] r_win_data [0:8];
   logic          r_win_valid;
   logic [9:0]    r_win_idx;
   logic [9:0]    r_win_cnt;
   logic          r_win_last;
   logic          w_in_xfer, w_out_xfer, w_emit, w_last_col;

   assign pix_ready  = reset && (r_state != S_DONE) && (!r_win_valid || win_ready);
   assign w_in_xfer  = pix_valid && pix_ready;
   assign w_out_xfer = r_win_valid && win_ready;
   assign w_last_col = (r_col == LAST_COL);
   assign w_emit     = w_in_xfer && (r_row >= RW'(2)) && (r_col >= CW'(2));

   // New right-hand column is {row r-2, row r-1, row r} at the current column.
   always_comb begin
      for (int ky = 0; ky < 3; ky++) begin
         w_win_sh[ky*3]   = r_win[ky*3+1];
         w_win_sh[ky*3+1] = r_win[ky*3+2];
      end
      w_win_sh[2] = r_lb1[r_col];
      w_win_sh[5] = r_lb0[r_col];
      w_win_sh[8] = pix_data;
   end

   // Line buffers are intentionally never cleared; rows 0-1 overwrite stale data.
   always_ff @(posedge clk) begin
      if (w_in_xfer) begin
         r_lb1[r_col] <= r_lb0[r_col];
         r_lb0[r_col] <= pix_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_FILL;
         r_col       <= '0;
         r_row       <= '0;
         r_win       <= '{default: '0};
         r_win_data  <= '{default: '0};
         r_win_valid <= 1'b0;
         r_win_idx   <= '0;
         r_win_cnt   <= '0;
         r_win_last  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_in_xfer) begin
            r_win <= w_win_sh;
            if (w_last_col) begin
               r_col <= '0;
               r_row <= (r_row == LAST_ROW) ? '0 : r_row + RW'(1);
            end else begin
               r_col <= r_col + CW'(1);
            end
         end
         // Window index is a running count of emitted windows within the frame.
         if (w_emit) begin
            r_win_valid <= 1'b1;
            r_win_data  <= w_win_sh;
            r_win_idx   <= r_win_cnt;
            r_win_last  <= (r_win_cnt == LAST_IDX);
            r_win_cnt   <= (r_win_cnt == LAST_IDX) ? '0 : r_win_cnt + 10'd1;
         end else if (w_out_xfer) begin
            r_win_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      frame_done  = 1'b0;
      case (r_state)
         S_FILL: if (w_in_xfer && (r_row == RW'(1)) && w_last_col) w_state_nxt = S_RUN;
         S_RUN:  if (w_out_xfer && r_win_last) w_state_nxt = S_DONE;
         S_DONE: begin
            frame_done  = 1'b1;
            w_state_nxt = S_FILL;
         end
         default: w_state_nxt = S_FILL;
      endcase
   end

   assign win_valid = r_win_valid;
   assign win_data  = r_win_data;
   assign win_idx   = r_win_idx;

endmodule

// File: tb/tb_im2col_window_gen.sv
// Scoreboard bench for im2col_window_gen: a raster driver pushes expected windows
// from a direct image model; a monitor pops and compares on every output transfer.
module tb_im2col_window_gen;
   localparam int W  = 28;
   localparam int H  = 28;
   localparam int NW = (W - 2) * (H - 2);

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pix_valid, pix_ready, win_valid, win_ready, frame_done;
   logic [7:0] pix_data;
   logic [7:0] win_data [0:8];
   logic [9:0] win_idx;

   im2col_window_gen #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
      .pix_ready(pix_ready), .win_valid(win_valid), .win_data(win_data),
      .win_idx(win_idx), .win_ready(win_ready), .frame_done(frame_done));

   always #5 clk = ~clk;

   int          n_cmp = 0, n_bad = 0, n_rx = 0, n_fd = 0;
   int          ready_pct = 100, idle_pct = 0;
   bit          chk_lat = 0;
   int          exp_idx[$];
   logic [71:0] exp_dat[$];

   task automatic chk(string nm, longint act, longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] px(int r, int c, int off);
      return 8'((r * W + c + off) & 255);
   endfunction

   function automatic logic [71:0] pack_out();
      logic [71:0] v;
      for (int j = 0; j < 9; j++) v[j*8 +: 8] = win_data[j];
      return v;
   endfunction

   // Expected window for the pixel at (r,c): kernel element j = ky*3+kx.
   task automatic push_exp(int r, int c, int off);
      logic [71:0] v;
      for (int j = 0; j < 9; j++) v[j*8 +: 8] = px(r - 2 + j / 3, c - 2 + j % 3, off);
      exp_idx.push_back((r - 2) * (W - 2) + (c - 2));
      exp_dat.push_back(v);
   endtask

   initial begin
      win_ready = 1'b1;
      forever begin
         @(negedge clk);
         win_ready = ($urandom_range(99) < ready_pct);
      end
   end

   // Monitor: samples 2 time units after each falling edge.
   bit          prev_stall = 0, prev_last = 0;
   logic [9:0]  prev_idx;
   logic [71:0] prev_dat;
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            prev_stall = 0;
            prev_last  = 0;
         end else begin
            if (prev_last) chk("frame_done_after_last", frame_done, 1);
            else if (frame_done) chk("frame_done_spurious", frame_done, 0);
            if (frame_done) begin
               n_fd++;
               chk("pix_ready_in_done", pix_ready, 0);
            end
            if (prev_stall) begin
               chk("stall_valid", win_valid, 1);
               chk("stall_idx", win_idx, prev_idx);
               chk("stall_data", pack_out(), prev_dat);
            end
            if (win_valid && !win_ready) chk("stall_pix_ready", pix_ready, 0);
            prev_last = 0;
            if (win_valid && win_ready) begin
               n_rx++;
               if (exp_idx.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_window: got idx %0d expected none", win_idx);
               end else begin
                  chk("win_idx", win_idx, exp_idx.pop_front());
                  chk("win_data", pack_out(), exp_dat.pop_front());
               end
               prev_last = (win_idx == 10'(NW - 1));
            end
            prev_stall = win_valid && !win_ready;
            prev_idx   = win_idx;
            prev_dat   = pack_out();
         end
      end
   end

   task automatic put_px(int r, int c, int off);
      int tries = 0;
      bit acc;
      @(negedge clk);
      #1;
      while (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
         pix_valid = 1'b0;
         @(negedge clk);
         #1;
      end
      pix_valid = 1'b1;
      pix_data  = px(r, c, off);
      forever begin
         acc = pix_ready;
         if (chk_lat && r == 2 && c == 2) chk("valid_before_2_2", win_valid, 0);
         @(posedge clk);
         if (acc) break;
         tries++;
         if (tries > 5000) begin
            $display("FAIL pix_accept_timeout: got no accept expected accept at (%0d,%0d)", r, c);
            $fatal(1);
         end
         @(negedge clk);
         #1;
      end
      if (r >= 2 && c >= 2) push_exp(r, c, off);
      if (chk_lat && r == 2 && c == 2) begin
         #1;
         chk("latency_valid", win_valid, 1);
         chk("latency_idx", win_idx, 0);
      end
   endtask

   task automatic do_reset();
      logic [7:0] orv;
      @(negedge clk);
      #3;
      reset = 1'b0;
      #1;
      orv = '0;
      for (int j = 0; j < 9; j++) orv |= win_data[j];
      chk("rst_win_valid", win_valid, 0);
      chk("rst_win_idx", win_idx, 0);
      chk("rst_win_data", orv, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_pix_ready", pix_ready, 0);
      pix_valid = 1'b0;
      exp_idx.delete();
      exp_dat.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Sends frames with the given offsets; stops early with a reset at (rst_r, rst_c).
   task automatic send(int off, int rst_r, int rst_c, output bit aborted);
      aborted = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            if (r == rst_r && c == rst_c) begin
               do_reset();
               aborted = 1;
               return;
            end
            put_px(r, c, off);
         end
   endtask

   task automatic finish_frames(int rx0, int fd0, int k, string nm);
      int cyc = 0;
      @(negedge clk);
      #1;
      pix_valid = 1'b0;
      while (n_fd < fd0 + k && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
      if (n_fd < fd0 + k) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_done_timeout: got %0d frame_done expected %0d", nm, n_fd - fd0, k);
      end
      repeat (5) @(negedge clk);
      chk({nm, "_windows"}, n_rx - rx0, NW * k);
      chk({nm, "_frame_done_count"}, n_fd - fd0, k);
      chk({nm, "_queue_empty"}, exp_idx.size(), 0);
   endtask

   initial begin
      int  rx0, fd0;
      bit  ab;
      pix_valid = 1'b0;
      pix_data  = '0;
      #12;
      chk("reset_win_valid", win_valid, 0);
      chk("reset_win_idx", win_idx, 0);
      chk("reset_frame_done", frame_done, 0);
      chk("reset_pix_ready", pix_ready, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("pix_ready_after_reset", pix_ready, 1);

      // Ramp frame, no backpressure, with first-window latency check.
      chk_lat = 1;
      rx0 = n_rx; fd0 = n_fd;
      send(0, -1, -1, ab);
      chk_lat = 0;
      finish_frames(rx0, fd0, 1, "ramp");

      // Random 50% output backpressure.
      ready_pct = 50;
      rx0 = n_rx; fd0 = n_fd;
      send(0, -1, -1, ab);
      finish_frames(rx0, fd0, 1, "backpressure");
      ready_pct = 100;

      // Back-to-back frames, second offset by 100.
      rx0 = n_rx; fd0 = n_fd;
      send(0, -1, -1, ab);
      send(100, -1, -1, ab);
      finish_frames(rx0, fd0, 2, "b2b");

      // Reset mid-frame at pixel (10,5), then a clean ramp frame.
      send(0, 10, 5, ab);
      chk("reset_abort_taken", ab, 1);
      rx0 = n_rx; fd0 = n_fd;
      chk_lat = 1;
      send(0, -1, -1, ab);
      chk_lat = 0;
      finish_frames(rx0, fd0, 1, "post_reset");

      // 30% idle input gaps.
      idle_pct = 30;
      rx0 = n_rx; fd0 = n_fd;
      send(0, -1, -1, ab);
      finish_frames(rx0, fd0, 1, "gaps");
      idle_pct = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
